// File: rtl/moxie_wb_ram_slave.sv
// Wishbone classic slave: 16-bit word-addressed RAM with byte lanes and a
// programmable wait-state count; out-of-window accesses terminate with err.
module moxie_wb_ram_slave #(
  parameter int          ADDR_WIDTH  = 12,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  // state | meaning
  // IDLE  | waiting for cyc & stb; also the mandatory turnaround cycle
  // WAIT  | counting wait states down to zero
  // ACK   | one-cycle normal termination
  // ERR   | one-cycle error termination (address outside window)

  generate
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
      $error("moxie_wb_ram_slave: WAIT_STATES must be within 0..15");
    end
  endgenerate

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, ERR} state_t;

  state_t                state, state_d;
  logic [3:0]            cnt, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_eff;
  logic [15:0]           dat_q, dat_eff;
  logic [1:0]            sel_q, sel_eff;
  logic                  we_q, we_eff;
  logic                  req, hit, enter_ack;
  logic [15:0]           mem [DEPTH];
  logic                  unused_adr0;

  assign unused_adr0 = wb_adr_i[0];
  assign req = wb_cyc_i & wb_stb_i;
  assign hit = (wb_adr_i[31:ADDR_WIDTH+1] == BASE_ADDR[31:ADDR_WIDTH+1]);

  // With zero wait states ACK is entered straight from IDLE, so the live
  // bus inputs must be used at that edge instead of the captured copies.
  assign idx_eff = (state == IDLE) ? wb_adr_i[ADDR_WIDTH:1] : idx_q;
  assign dat_eff = (state == IDLE) ? wb_dat_i : dat_q;
  assign sel_eff = (state == IDLE) ? wb_sel_i : sel_q;
  assign we_eff  = (state == IDLE) ? wb_we_i  : we_q;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          if (!hit) begin
            state_d = ERR;
          end else if (WAIT_STATES == 0) begin
            state_d = ACK;
          end else begin
            state_d = WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt == 4'd0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_ack = (state_d == ACK);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      wb_dat_o <= 16'h0000;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (enter_ack && !we_eff) begin
        wb_dat_o <= mem[idx_eff];
      end else begin
        wb_dat_o <= 16'h0000;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (state == IDLE && req) begin
      idx_q <= wb_adr_i[ADDR_WIDTH:1];
      dat_q <= wb_dat_i;
      sel_q <= wb_sel_i;
      we_q  <= wb_we_i;
    end
  end

  // RAM is deliberately not reset; a reset edge only blocks the commit.
  always_ff @(posedge clk_i) begin
    if (!rst_i && enter_ack && we_eff) begin
      if (sel_eff[0]) mem[idx_eff][7:0]  <= dat_eff[7:0];
      if (sel_eff[1]) mem[idx_eff][15:8] <= dat_eff[15:8];
    end
  end

  assign wb_ack_o = (state == ACK);
  assign wb_err_o = (state == ERR);

endmodule

// File: tb/tb_moxie_wb_ram_slave.sv
// Directed bench for moxie_wb_ram_slave: one instance with 1 wait state and
// one with 3, sharing a bus whose cyc/stb are steered by use3.
module tb_moxie_wb_ram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [15:0] wdat = '0;
  logic [1:0]  sel = '0;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        use3 = 1'b0;

  logic [15:0] dat0, dat3;
  logic        ack0, ack3, err0, err3;
  logic [15:0] bus_dat;
  logic        bus_ack, bus_err;

  int total = 0;
  int bad = 0;
  int n_ack0 = 0, n_err0 = 0, n_ack3 = 0, n_err3 = 0;
  bit both_seen = 1'b0;

  always #5 clk = ~clk;

  moxie_wb_ram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(1), .BASE_ADDR(32'h0)) u_dut (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc & ~use3), .wb_stb_i(stb & ~use3),
    .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0));

  moxie_wb_ram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc & use3), .wb_stb_i(stb & use3),
    .wb_dat_o(dat3), .wb_ack_o(ack3), .wb_err_o(err3));

  assign bus_dat = use3 ? dat3 : dat0;
  assign bus_ack = use3 ? ack3 : ack0;
  assign bus_err = use3 ? err3 : err0;

  always @(negedge clk) begin
    if (ack0) n_ack0++;
    if (err0) n_err0++;
    if (ack3) n_ack3++;
    if (err3) n_err3++;
    if ((ack0 && err0) || (ack3 && err3)) both_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic xfer(input bit u3, input bit w, input logic [31:0] a,
                      input logic [15:0] d, input logic [1:0] s,
                      output logic [15:0] rd, output int lat,
                      output bit was_err, output bit tail_ok);
    @(negedge clk);
    use3 = u3; we = w; adr = a; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus_ack && !bus_err && lat < 20);
    rd = bus_dat;
    was_err = bus_err;
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    tail_ok = !bus_ack && !bus_err && (bus_dat == 16'h0000);
  endtask

  task automatic wr_chk(input bit u3, input logic [31:0] a, input logic [15:0] d,
                        input logic [1:0] s, input string tag);
    logic [15:0] rd;
    int lat;
    bit e, t;
    xfer(u3, 1'b1, a, d, s, rd, lat, e, t);
    chk({tag, "_lat"}, lat, u3 ? 4 : 2);
    chk({tag, "_tail"}, t, 1);
  endtask

  task automatic rd_chk(input bit u3, input logic [31:0] a, input logic [15:0] exp,
                        input string tag);
    logic [15:0] rd;
    int lat;
    bit e, t;
    xfer(u3, 1'b0, a, 16'h0, 2'b00, rd, lat, e, t);
    chk({tag, "_lat"}, lat, u3 ? 4 : 2);
    chk({tag, "_dat"}, rd, exp);
    chk({tag, "_tail"}, t, 1);
  endtask

  initial begin
    logic [15:0] rd;
    int lat, a0, e0, a3, e3, kprev, acks;
    bit e, t;
    logic [15:0] bb_exp [3];

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", ack0, 0);
    chk("rst_err", err0, 0);
    chk("rst_dat", dat0, 16'h0000);
    @(negedge clk); rst = 1'b0;

    // single read with one wait state
    wr_chk(0, 32'h0020, 16'h1357, 2'b11, "pre20");
    rd_chk(0, 32'h0020, 16'h1357, "rd20");

    // byte lanes
    wr_chk(0, 32'h0020, 16'hA55A, 2'b11, "wr_a55a");
    wr_chk(0, 32'h0020, 16'h1234, 2'b01, "wr_lo");
    rd_chk(0, 32'h0020, 16'hA534, "rd_a534");
    wr_chk(0, 32'h0020, 16'hFFFF, 2'b00, "wr_none");
    rd_chk(0, 32'h0020, 16'hA534, "rd_none");
    wr_chk(0, 32'h0021, 16'h7700, 2'b10, "wr_hi");
    rd_chk(0, 32'h0020, 16'h7734, "rd_hi");

    // out-of-window accesses
    wr_chk(0, 32'h0000, 16'h0BEE, 2'b11, "pre0");
    a0 = n_ack0;
    xfer(0, 1'b1, 32'h0000_2000, 16'hDEAD, 2'b11, rd, lat, e, t);
    chk("err_flag", e, 1);
    chk("err_lat", lat, 1);
    chk("err_dat", rd, 16'h0000);
    chk("err_tail", t, 1);
    chk("err_noack", n_ack0 - a0, 0);
    xfer(0, 1'b0, 32'h8000_0000, 16'h0, 2'b11, rd, lat, e, t);
    chk("err_hi_flag", e, 1);
    chk("err_hi_lat", lat, 1);
    rd_chk(0, 32'h0000, 16'h0BEE, "rd0_after_err");

    // back-to-back reads with stb held high
    wr_chk(0, 32'h0022, 16'h1111, 2'b11, "bb_w0");
    wr_chk(0, 32'h0024, 16'h2222, 2'b11, "bb_w1");
    wr_chk(0, 32'h0026, 16'h3333, 2'b11, "bb_w2");
    bb_exp[0] = 16'h1111; bb_exp[1] = 16'h2222; bb_exp[2] = 16'h3333;
    @(negedge clk);
    use3 = 1'b0; we = 1'b0; adr = 32'h0022; cyc = 1'b1; stb = 1'b1;
    acks = 0; kprev = 0;
    for (int k = 0; k < 30 && acks < 3; k++) begin
      @(posedge clk); #1;
      if (bus_ack) begin
        chk("bb_dat", bus_dat, {16'h0, bb_exp[acks]});
        if (acks > 0) chk("bb_gap", k - kprev, 3);
        kprev = k;
        acks++;
        adr = adr + 32'd2;
      end
    end
    cyc = 1'b0; stb = 1'b0;
    chk("bb_count", acks, 3);
    @(posedge clk); #1;

    // abort in WAIT with three wait states
    wr_chk(1, 32'h0100, 16'h0BAD, 2'b11, "ab_pre");
    a3 = n_ack3; e3 = n_err3;
    @(negedge clk);
    use3 = 1'b1; we = 1'b1; adr = 32'h0100; wdat = 16'hFFFF; sel = 2'b11;
    cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    cyc = 1'b0;
    chk("ab_noack", n_ack3 - a3, 0);
    chk("ab_noerr", n_err3 - e3, 0);
    rd_chk(1, 32'h0100, 16'h0BAD, "ab_rd");

    // reset during WAIT of a write
    wr_chk(0, 32'h0040, 16'h4444, 2'b11, "rs_pre");
    a0 = n_ack0; e0 = n_err0;
    @(negedge clk);
    use3 = 1'b0; we = 1'b1; adr = 32'h0040; wdat = 16'hEEEE; sel = 2'b11;
    cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    chk("rs_ack", ack0, 0);
    chk("rs_err", err0, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("rs_noack", n_ack0 - a0, 0);
    chk("rs_noerr", n_err0 - e0, 0);
    rd_chk(0, 32'h0040, 16'h4444, "rs_rd");

    chk("ack_err_excl", both_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/moxie_wb_ram_slave.md
Name: moxie_wb_ram_slave

Overview:
- Wishbone classic slave: 16-bit word-addressed on-chip RAM with byte lanes and a programmable wait-state count.
- Responder end of the 16-bit moxielite Wishbone master bus; serves as boot/scratch memory on the SoC fabric.
- Out-of-window accesses are terminated with an error instead of ack, so address-decode bugs are visible on the bus.

Parameters:
- ADDR_WIDTH, 12, number of word-address bits; depth = 2**ADDR_WIDTH 16-bit words.
- WAIT_STATES, 1, extra cycles inserted before ack; legal range 0..15.
- BASE_ADDR, 32'h0000_0000, byte base address of the RAM window; must be aligned to 2**(ADDR_WIDTH+1).

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- wb_adr_i  in  32  byte address; bit 0 ignored.
- wb_dat_i  in  16  write data.
- wb_sel_i  in  2  byte lanes: [1] = bits 15:8, [0] = bits 7:0.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_cyc_i  in  1  bus cycle active.
- wb_stb_i  in  1  transfer strobe.
- wb_dat_o  out  16  read data; valid only while wb_ack_o = 1.
- wb_ack_o  out  1  normal termination, one-cycle pulse.
- wb_err_o  out  1  error termination, one-cycle pulse.

Behaviour:
- Reset (one clk_i edge with rst_i = 1): state IDLE, wb_ack_o = 0, wb_err_o = 0, wb_dat_o = 16'h0000, wait counter = 0. RAM contents are not cleared.
- Request: wb_cyc_i & wb_stb_i sampled high in IDLE.
- Address decode: hit = (wb_adr_i[31:ADDR_WIDTH+1] == BASE_ADDR[31:ADDR_WIDTH+1]). Word index = wb_adr_i[ADDR_WIDTH:1].
- Address, data, sel and we are captured at the request edge; later changes on those inputs are ignored for that transfer.
- State machine:
  - IDLE:
    - request & !hit -> ERR.
    - request & hit & WAIT_STATES == 0 -> ACK.
    - request & hit & WAIT_STATES > 0 -> WAIT; counter loads WAIT_STATES-1.
    - otherwise stay in IDLE.
  - WAIT: counter decrements each cycle; counter == 0 -> ACK.
  - ACK: wb_ack_o = 1 for exactly this cycle, then -> IDLE.
  - ERR: wb_err_o = 1 for exactly this cycle, then -> IDLE. RAM untouched; wb_dat_o = 0.
- Latency: ack is high in the cycle WAIT_STATES+1 cycles after the request edge. Error is high in the cycle immediately after the request edge.
- Mandatory turnaround: after ACK or ERR the block spends at least one cycle in IDLE with ack/err low. If stb is still high in that IDLE cycle, it is taken as a new request (classic, non-pipelined). Consequence: minimum transfer period is WAIT_STATES+2 cycles.
- Write commit: RAM is written on the clock edge that enters ACK, only for lanes with wb_sel_i bit = 1. sel = 2'b00 write still acks and changes nothing.
- Read: wb_dat_o is registered on the edge entering ACK with the full 16-bit word; wb_sel_i is ignored. wb_dat_o returns to 0 on the edge leaving ACK.
- Abort: if wb_cyc_i or wb_stb_i is low in any WAIT cycle -> IDLE next edge; no ack, no write.
- Reset mid-transfer: rst_i wins over every state. No write is committed at a reset edge, and ack/err are low the next cycle.
- Invariants:
  - wb_ack_o and wb_err_o are never both 1.
  - There is never more than one termination per request.
  - Neither output is driven when wb_cyc_i was low at the request edge.
- Counter width is 4 bits; WAIT_STATES > 15 is illegal and must trip an elaboration-time check.

Test Plan:
- Reset, then single read of word 0x010 with WAIT_STATES=1 -> ack in the 2nd cycle after strobe; wb_dat_o = preloaded value; ack high for exactly 1 cycle.
- Write 16'hA55A with sel=2'b11 to address 0x0020, then write 16'h1234 with sel=2'b01 to the same address, then read -> returns 16'hA534.
- Access address BASE_ADDR + 2**(ADDR_WIDTH+1), i.e. 0x2000 for the defaults -> wb_err_o pulses one cycle after strobe; no ack; a following read of word 0 is unchanged.
- Hold stb high continuously across 3 reads to consecutive addresses (master updates address after each ack) -> 3 acks spaced WAIT_STATES+2 = 3 cycles apart; data correct for each address.
- Drop wb_stb_i in the WAIT cycle of a write of 16'hFFFF, using WAIT_STATES=3 -> no ack; a subsequent read shows the old data.
- Assert rst_i during WAIT of a write -> ack and err stay low; state IDLE; target word unchanged. A following normal read acks with the old data.
